mult_arbiter: RTL and testbench

- Shares one multiplier unit (start/ready/done handshake, 2*WIDTH-bit product) among NUM_REQ requesters.
- Uses round-robin arbitration and issues one operation at a time.
- Routes each product back to the requester that issued it.
- A watchdog aborts an operation that never completes and returns an error response instead of hanging the system.

---
 rtl/mult_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one start/done multiplier among NUM_REQ requesters.
// A watchdog turns a multiplier that never finishes into an error response.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplicand,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplier,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_product,
    output logic                       rsp_err,
    output logic                       mult_start,
    output logic [WIDTH-1:0]           mult_multiplicand,
    output logic [WIDTH-1:0]           mult_multiplier,
    input  logic                       mult_ready,
    input  logic                       mult_done,
    input  logic [2*WIDTH-1:0]         mult_product
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [GW-1:0]        rr_ptr_r, rr_ptr_s;
    logic [GW-1:0]        grant_r, grant_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [WIDTH-1:0]     mcand_r, mcand_s;
    logic [WIDTH-1:0]     mplier_r, mplier_s;
    logic                 start_r, start_s;
    logic [NUM_REQ-1:0]   rsp_valid_r, rsp_valid_s;
    logic [2*WIDTH-1:0]   rsp_product_r, rsp_product_s;
    logic                 rsp_err_r, rsp_err_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic                 found_s;
    logic [GW-1:0]        pick_s;
    logic [GW:0]          sum_s;
    logic [GW-1:0]        idx_s;

    // Round-robin search: walking downward and overwriting leaves the first hit at or after rr_ptr.
    always_comb begin
        found_s = |req_valid;
        pick_s  = {GW{1'b0}};
        sum_s   = {(GW+1){1'b0}};
        idx_s   = {GW{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum_s  = {1'b0, rr_ptr_r} + (GW+1)'(k);
            idx_s  = (sum_s >= (GW+1)'(NUM_REQ)) ? GW'(sum_s - (GW+1)'(NUM_REQ)) : GW'(sum_s);
            pick_s = req_valid[idx_s] ? idx_s : pick_s;
        end
    end

    // Next-state and next-output logic for the issue/wait/respond sequence.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        grant_s       = grant_r;
        cnt_s         = cnt_r;
        mcand_s       = mcand_r;
        mplier_s      = mplier_r;
        start_s       = 1'b0;
        rsp_valid_s   = rsp_valid_r;
        rsp_product_s = rsp_product_r;
        rsp_err_s     = rsp_err_r;
        req_ready_s   = {NUM_REQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (found_s && mult_ready) begin
                    req_ready_s[pick_s] = 1'b1;
                    grant_s  = pick_s;
                    mcand_s  = req_multiplicand[int'(pick_s)*WIDTH +: WIDTH];
                    mplier_s = req_multiplier[int'(pick_s)*WIDTH +: WIDTH];
                    start_s  = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_s   = {CW{1'b0}};
                state_s = BUSY;
            end
            BUSY: begin
                cnt_s = cnt_r + CW'(1);
                // A completion on the threshold cycle still wins over the abort.
                if (mult_done) begin
                    rsp_product_s = mult_product;
                    rsp_err_s     = 1'b0;
                    rsp_valid_s   = ONE_HOT0 << grant_r;
                    state_s       = RESP;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    rsp_product_s = {(2*WIDTH){1'b0}};
                    rsp_err_s     = 1'b1;
                    rsp_valid_s   = ONE_HOT0 << grant_r;
                    state_s       = RESP;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                if (rsp_ready[grant_r]) begin
                    rsp_valid_s   = {NUM_REQ{1'b0}};
                    rsp_product_s = {(2*WIDTH){1'b0}};
                    rsp_err_s     = 1'b0;
                    rr_ptr_s      = (grant_r == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : grant_r + GW'(1);
                    state_s       = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            rr_ptr_r      <= {GW{1'b0}};
            grant_r       <= {GW{1'b0}};
            cnt_r         <= {CW{1'b0}};
            mcand_r       <= {WIDTH{1'b0}};
            mplier_r      <= {WIDTH{1'b0}};
            start_r       <= 1'b0;
            rsp_valid_r   <= {NUM_REQ{1'b0}};
            rsp_product_r <= {(2*WIDTH){1'b0}};
            rsp_err_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            grant_r       <= grant_s;
            cnt_r         <= cnt_s;
            mcand_r       <= mcand_s;
            mplier_r      <= mplier_s;
            start_r       <= start_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_product_r <= rsp_product_s;
            rsp_err_r     <= rsp_err_s;
        end
    end

    // The accept strobe is combinational, so it is held low while reset is asserted.
    assign req_ready         = req_ready_s & {NUM_REQ{reset_n}};
    assign rsp_valid         = rsp_valid_r;
    assign rsp_product       = rsp_product_r;
    assign rsp_err           = rsp_err_r;
    assign mult_start        = start_r;
    assign mult_multiplicand = mcand_r;
    assign mult_multiplier   = mplier_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: behavioural multiplier, scoreboard of expected
// responses, immediate-assertion comparisons.
module tb_mult_arbiter;

    typedef struct {
        int          id;
        logic [15:0] prod;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_multiplicand;
    logic [31:0] req_multiplier;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_product;
    logic        rsp_err;
    logic        mult_start;
    logic [7:0]  mult_multiplicand;
    logic [7:0]  mult_multiplier;
    logic        mult_ready = 1'b0;
    logic        mult_done = 1'b0;
    logic [15:0] mult_product = 16'd0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    int          m_lat = 3;
    bit          m_hang = 1'b0;
    bit          m_busy = 1'b0;
    int          m_rem = 0;
    logic [15:0] m_a = 16'd0;
    logic [15:0] m_b = 16'd0;

    mult_arbiter #(.NUM_REQ(4), .WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mult_start(mult_start), .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
        .mult_ready(mult_ready), .mult_done(mult_done), .mult_product(mult_product)
    );

    always #5 clk = ~clk;

    // Multiplier: done pulses m_lat cycles after the start cycle; m_hang withholds it.
    always @(posedge clk) begin
        mult_done <= 1'b0;
        if (mult_start) begin
            m_busy = 1'b1;
            m_rem  = m_lat;
            m_a    = {8'h00, mult_multiplicand};
            m_b    = {8'h00, mult_multiplier};
        end
        if (m_busy) begin
            m_rem = m_rem - 1;
            if (m_rem <= 0 && !m_hang) begin
                mult_done    <= 1'b1;
                mult_product <= m_a * m_b;
                m_busy = 1'b0;
            end
        end
        mult_ready <= !m_busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Response monitor: pops the scoreboard on each handshake and checks exclusivity.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("onehot", 32'($onehot0(req_ready) && $onehot0(rsp_valid) && !((|req_ready) && (|rsp_valid))), 32'd1);
            if ((rsp_valid & rsp_ready) != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(oh(2'(e.id))));
                    chk("rsp_product", 32'(rsp_product), 32'(e.prod));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] i, input logic [7:0] a, input logic [7:0] b);
        req_valid[i] = 1'b1;
        req_multiplicand[int'(i)*8 +: 8] = a;
        req_multiplier[int'(i)*8 +: 8]   = b;
    endtask

    task automatic wait_grant(input logic [1:0] id, input int max);
        int n = 0;
        #1;
        while (req_ready == 4'b0000 && n < max) begin
            tick();
            n++;
        end
        chk("grant", 32'(req_ready), 32'(oh(id)));
    endtask

    // Wait for the grant, record the expected response, then pass the accept edge.
    task automatic issue(input logic [1:0] id, input logic [15:0] prod, input logic err, input bit keep);
        wait_grant(id, 40);
        sb.push_back('{id: int'(id), prod: prod, err: err});
        tick();
        chk("mult_start", 32'(mult_start), 32'd1);
        if (!keep) req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int n, input int max);
        n = 0;
        while (rsp_valid == 4'b0000 && n < max) begin
            tick();
            n++;
        end
        chk("rsp_seen", 32'(n < max), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        req_valid = 4'b0000;
        req_multiplicand = 32'd0;
        req_multiplier = 32'd0;
        rsp_ready = 4'b1111;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_product", 32'(rsp_product), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);
        chk("rst_mcand", 32'(mult_multiplicand), 32'd0);
        chk("rst_mplier", 32'(mult_multiplier), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single request 13*11, multiplier latency 9: response 10 cycles after start.
        m_lat = 9;
        set_req(2'd0, 8'd13, 8'd11);
        issue(2'd0, 16'd143, 1'b0, 1'b0);
        chk("op_mcand", 32'(mult_multiplicand), 32'd13);
        chk("op_mplier", 32'(mult_multiplier), 32'd11);
        chk("no_ready_issue", 32'(req_ready), 32'd0);
        tick();
        chk("start_pulse", 32'(mult_start), 32'd0);
        wait_rsp(n, 40);
        chk("done_latency", 32'(n + 1), 32'd10);
        tick();
        chk("rsp_drop", 32'(rsp_valid), 32'd0);

        // Round robin from a fresh pointer: all four held valid.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        m_lat = 2;
        for (int i = 0; i < 4; i++) set_req(2'(i), 8'(i + 1), 8'd2);
        for (int k = 0; k < 5; k++) issue(2'(k % 4), 16'(((k % 4) + 1) * 2), 1'b0, 1'b1);
        req_valid = 4'b0000;
        wait_rsp(n, 40);
        tick();

        // Backpressure on requester 2 while requesters 1 and 3 wait.
        rsp_ready[2] = 1'b0;
        set_req(2'd2, 8'd7, 8'd9);
        issue(2'd2, 16'd63, 1'b0, 1'b0);
        set_req(2'd1, 8'd3, 8'd3);
        set_req(2'd3, 8'd5, 8'd5);
        wait_rsp(n, 40);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'(4'b0100));
            chk("bp_product", 32'(rsp_product), 32'd63);
            chk("bp_no_accept", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready[2] = 1'b1;
        tick();
        chk("bp_release", 32'(rsp_valid), 32'd0);
        issue(2'd3, 16'd25, 1'b0, 1'b0);
        wait_rsp(n, 40);
        tick();
        issue(2'd1, 16'd9, 1'b0, 1'b0);
        wait_rsp(n, 40);
        tick();

        // Hung multiplier: 16 cycles in BUSY, error response on the next cycle.
        m_hang = 1'b1;
        set_req(2'd0, 8'd4, 8'd4);
        issue(2'd0, 16'd0, 1'b1, 1'b0);
        wait_rsp(n, 40);
        chk("timeout_latency", 32'(n), 32'd17);
        chk("timeout_err", 32'(rsp_err), 32'd1);
        chk("timeout_product", 32'(rsp_product), 32'd0);
        tick();
        set_req(2'd1, 8'd6, 8'd7);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wait_mult_ready", 32'(req_ready), 32'd0);
            tick();
        end
        m_hang = 1'b0;
        issue(2'd1, 16'd42, 1'b0, 1'b0);
        wait_rsp(n, 40);
        tick();

        // 255*255 with done landing on the watchdog threshold cycle.
        m_lat = 16;
        set_req(2'd2, 8'd255, 8'd255);
        issue(2'd2, 16'd65025, 1'b0, 1'b0);
        wait_rsp(n, 40);
        chk("threshold_latency", 32'(n), 32'd17);
        tick();

        // Reset in BUSY with the pointer at 3; afterwards requester 0 wins, 0*200.
        m_lat = 9;
        set_req(2'd3, 8'd10, 8'd10);
        wait_grant(2'd3, 40);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        set_req(2'd0, 8'd0, 8'd200);
        set_req(2'd2, 8'd1, 8'd1);
        set_req(2'd3, 8'd10, 8'd10);
        reset_n = 1'b0;
        #1;
        chk("ar_req_ready", 32'(req_ready), 32'd0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_mult_start", 32'(mult_start), 32'd0);
        chk("ar_mcand", 32'(mult_multiplicand), 32'd0);
        chk("ar_rsp_product", 32'(rsp_product), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        m_lat = 1;
        issue(2'd0, 16'd0, 1'b0, 1'b0);
        req_valid = 4'b0000;
        wait_rsp(n, 40);
        tick();
        repeat (12) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
